// File: rtl/machine_output.sv
`default_nettype none
// ============================================================================
// Module   : machine_output
// Brief    : MM:SS countdown timer with 1 Hz tick, DONE blink, and a 4-digit
//            multiplexed common-anode 7-segment display driver.
// Revision : 1.0 - initial release
// ============================================================================
module machine_output #(
   parameter int TICK_DIV  = 50_000_000,
   parameter int SCAN_DIV  = 50_000,
   parameter int BLINK_DIV = 25_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] min_set,
   input  logic [7:0] sec_set,
   input  logic       count_begin,
   input  logic       stop,
   output logic [7:0] seg,
   output logic [3:0] dig_sel,
   output logic [7:0] min_left,
   output logic [7:0] sec_left,
   output logic       running,
   output logic       time_up,
   output logic       done_pulse
);

   localparam int c_tick_w  = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
   localparam int c_scan_w  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int c_blink_w = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [c_tick_w-1:0]  c_tick_last  = c_tick_w'(TICK_DIV - 1);
   localparam logic [c_scan_w-1:0]  c_scan_last  = c_scan_w'(SCAN_DIV - 1);
   localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_DIV - 1);

   localparam logic [1:0] c_idle = 2'd0;
   localparam logic [1:0] c_run  = 2'd1;
   localparam logic [1:0] c_done = 2'd2;

   localparam logic [3:0] c_dig_reset = 4'b0111;

   function automatic logic [7:0] clamp59(input logic [7:0] v);
      return (v > 8'd59) ? 8'd59 : v;
   endfunction

   // {g,f,e,d,c,b,a}, active-low
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] code;
      case (d)
         4'd0:    code = 7'h40;
         4'd1:    code = 7'h79;
         4'd2:    code = 7'h24;
         4'd3:    code = 7'h30;
         4'd4:    code = 7'h19;
         4'd5:    code = 7'h12;
         4'd6:    code = 7'h02;
         4'd7:    code = 7'h78;
         4'd8:    code = 7'h00;
         4'd9:    code = 7'h10;
         default: code = 7'h7F;
      endcase
      return code;
   endfunction

   logic [1:0]           r_state;
   logic                 r_begin_d;
   logic [c_tick_w-1:0]  r_tick_cnt;
   logic [c_scan_w-1:0]  r_scan_cnt;
   logic [c_blink_w-1:0] r_blink_cnt;
   logic                 r_blink_on;

   logic       w_start;
   logic [7:0] w_min_set_c;
   logic [7:0] w_sec_set_c;
   logic       w_tick_wrap;
   logic       w_scan_wrap;
   logic       w_blink_wrap;
   logic [1:0] w_state_nxt;
   logic [7:0] w_min_nxt;
   logic [7:0] w_sec_nxt;

   assign w_start      = count_begin & ~r_begin_d;
   assign w_min_set_c  = clamp59(min_set);
   assign w_sec_set_c  = clamp59(sec_set);
   assign w_tick_wrap  = (r_tick_cnt  == c_tick_last);
   assign w_scan_wrap  = (r_scan_cnt  == c_scan_last);
   assign w_blink_wrap = (r_blink_cnt == c_blink_last);

   // stop outranks start, start outranks the tick; start is ignored while running
   always_comb begin
      w_state_nxt = r_state;
      w_min_nxt   = min_left;
      w_sec_nxt   = sec_left;
      if (stop) begin
         w_state_nxt = c_idle;
         w_min_nxt   = 8'd0;
         w_sec_nxt   = 8'd0;
      end else if (w_start && (r_state != c_run)) begin
         w_min_nxt   = w_min_set_c;
         w_sec_nxt   = w_sec_set_c;
         w_state_nxt = ((w_min_set_c == 8'd0) && (w_sec_set_c == 8'd0)) ? c_done : c_run;
      end else if ((r_state == c_run) && w_tick_wrap) begin
         if (sec_left != 8'd0) begin
            w_sec_nxt = sec_left - 8'd1;
            if ((min_left == 8'd0) && (sec_left == 8'd1)) begin
               w_state_nxt = c_done;
            end
         end else begin
            w_min_nxt = min_left - 8'd1;
            w_sec_nxt = 8'd59;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= c_idle;
         r_begin_d  <= 1'b0;
         min_left   <= 8'd0;
         sec_left   <= 8'd0;
         running    <= 1'b0;
         time_up    <= 1'b0;
         done_pulse <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_begin_d  <= count_begin;
         min_left   <= w_min_nxt;
         sec_left   <= w_sec_nxt;
         running    <= (w_state_nxt == c_run);
         time_up    <= (w_state_nxt == c_done);
         done_pulse <= (w_state_nxt == c_done) && (r_state != c_done);
      end
   end

   // Any cycle that is not a continuation of RUN leaves the divider at zero,
   // which also gives the load-on-start clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_tick_cnt <= '0;
      end else if ((r_state != c_run) || (w_state_nxt != c_run)) begin
         r_tick_cnt <= '0;
      end else if (w_tick_wrap) begin
         r_tick_cnt <= '0;
      end else begin
         r_tick_cnt <= r_tick_cnt + c_tick_w'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end else if ((r_state == c_done) && (w_state_nxt == c_done)) begin
         if (w_blink_wrap) begin
            r_blink_cnt <= '0;
            r_blink_on  <= ~r_blink_on;
         end else begin
            r_blink_cnt <= r_blink_cnt + c_blink_w'(1);
         end
      end else begin
         r_blink_cnt <= '0;
         r_blink_on  <= 1'b1;
      end
   end

   logic [7:0] w_disp_min;
   logic [7:0] w_disp_sec;
   logic [3:0] w_dig_nxt;
   logic [3:0] w_digit;
   logic [7:0] w_seg_nxt;

   assign w_disp_min = (r_state == c_idle) ? w_min_set_c : min_left;
   assign w_disp_sec = (r_state == c_idle) ? w_sec_set_c : sec_left;
   assign w_dig_nxt  = w_scan_wrap ? {dig_sel[0], dig_sel[3:1]} : dig_sel;

   // seg is built for the digit that will be selected after this edge
   always_comb begin
      w_digit = 4'd0;
      case (w_dig_nxt)
         4'b0111: w_digit = 4'(w_disp_min / 8'd10);
         4'b1011: w_digit = 4'(w_disp_min % 8'd10);
         4'b1101: w_digit = 4'(w_disp_sec / 8'd10);
         4'b1110: w_digit = 4'(w_disp_sec % 8'd10);
         default: w_digit = 4'd0;
      endcase
      if ((r_state == c_done) && !r_blink_on) begin
         w_seg_nxt = 8'hFF;
      end else begin
         w_seg_nxt = {w_dig_nxt[2], seg7(w_digit)};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_scan_cnt <= '0;
         dig_sel    <= c_dig_reset;
         seg        <= 8'hFF;
      end else begin
         r_scan_cnt <= w_scan_wrap ? '0 : (r_scan_cnt + c_scan_w'(1));
         dig_sel    <= w_dig_nxt;
         seg        <= w_seg_nxt;
      end
   end

endmodule
`default_nettype wire
